// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex driver for an N-digit 7-segment display
// with leading-zero blanking, per-digit decimal points and frame-synchronous updates.
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;
  // active-low abcdefg patterns, nibble 0 in the least significant slot
  localparam logic [16*7-1:0] SEG_LUT = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick, frame_end, blank;
  logic [3:0]              nib;
  logic [6:0]              seg_al;
  logic [NUM_DIGITS-1:0]   an_sel;
  always_comb begin
    tick         = cnt_q == CW'(REFRESH_DIV - 1);
    frame_end    = tick && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = frame_end ? '0 : idx_q + IW'(tick);
    pend_val_d   = load ? value : pend_val_q;
    pend_dp_d    = load ? dp_in : pend_dp_q;
    // transfer reads the registered pending, so a coincident load waits a frame
    disp_val_d   = frame_end ? pend_val_q : disp_val_q;
    disp_dp_d    = frame_end ? pend_dp_q : disp_dp_q;
    frame_done_d = frame_end;
    nib          = disp_val_q[{idx_q, 2'b00} +: 4];
    // digit is a leading zero when it and every higher nibble are zero
    blank        = blank_lz && idx_q != '0 && (disp_val_q >> {idx_q, 2'b00}) == '0;
    seg_al       = (enable && !blank) ? SEG_LUT[7*nib +: 7] : 7'h7F;
    an_sel       = enable ? (AN_ONE << idx_q) : '0;
    seg_d        = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
    dp_d         = (enable && disp_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    an_d         = AN_ACTIVE_LOW ? ~an_sel : an_sel;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACTIVE_LOW;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench; expected digit slots are queued per frame
// and a monitor compares them while the scanner presents each digit.
module tb_seven_seg_scanner;
  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [6:0] D0 = 7'b0000001;
  localparam logic [6:0] DA = 7'b0001000;
  typedef struct {
    int         f;
    int         d;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  int          tests = 0;
  int          fails = 0;
  int          ph = -1;
  int          frame_no = 0;
  exp_t        q[$];
  always #5 clk = ~clk;
  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .nrst(nrst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );
  // frame/phase tracker: phase 0 is the first cycle a new frame's digit 0 is shown
  always @(posedge clk or negedge nrst) begin
    if (!nrst) ph <= -1;
    else begin
      if (frame_done || ph == -1) frame_no <= frame_no + 1;
      ph <= frame_done ? 0 : ph + 1;
    end
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic expf(int f, logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0,
                      logic [3:0] dpm, logic [3:0] offm);
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.f   = f;
      e.d   = d;
      e.an  = offm[d] ? 4'hF : ~(4'b0001 << d);
      e.seg = offm[d] ? OFF : s[d];
      e.dp  = offm[d] ? 1'b1 : ~dpm[d];
      q.push_back(e);
    end
  endtask
  task automatic sync(int f, int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(frame_no == f && ph == p) && n < 300);
    check($sformatf("sync_f%0d_ph%0d", f, p), 32'(frame_no == f && ph == p), 32'd1);
  endtask
  task automatic do_load(logic [15:0] v, logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].f < frame_no) begin
      check($sformatf("missed_f%0d_d%0d", q[0].f, q[0].d), 32'(frame_no), 32'(q[0].f));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].f == frame_no && ph >= 0 && ph < 16 && q[0].d == ph / 4) begin
      check($sformatf("f%0d_d%0d_ph%0d_{an,seg,dp}", frame_no, q[0].d, ph),
            32'({an, seg, dp}), 32'({q[0].an, q[0].seg, q[0].dp}));
      if (ph % 4 == 3) void'(q.pop_front());
    end
    if (nrst && (frame_done || ph == 15))
      check($sformatf("frame_done_f%0d_ph%0d", frame_no, ph), 32'(frame_done && ph == 15), 32'd1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    expf(1, D0, D0, D0, D0, 4'b0000, 4'b0000);
    nrst = 1'b1;
    sync(1, 3);
    expf(2, 7'b1001111, 7'b0010010, DA, 7'b0111000, 4'b0000, 4'b0000);
    do_load(16'h12AF, 4'b0000);
    sync(2, 3);
    blank_lz = 1'b1;
    expf(3, OFF, OFF, OFF, 7'b0100100, 4'b0010, 4'b0000);
    do_load(16'h0005, 4'b0010);
    sync(3, 3);
    expf(4, OFF, OFF, OFF, D0, 4'b0000, 4'b0000);
    do_load(16'h0000, 4'b0000);
    sync(4, 3);
    expf(5, 7'b0000110, 7'b0110001, 7'b0001111, 7'b0110000, 4'b0000, 4'b0000);
    do_load(16'h3C7E, 4'b0000);
    sync(5, 14);
    expf(6, 7'b0000110, 7'b0110001, 7'b0001111, 7'b0110000, 4'b0000, 4'b0000);
    expf(7, DA, DA, DA, DA, 4'b0000, 4'b0100);
    do_load(16'hAAAA, 4'b0000);
    sync(7, 7);
    enable = 1'b0;
    sync(7, 11);
    enable = 1'b1;
    q.push_back('{8, 0, 4'b1110, DA, 1'b1});
    sync(8, 6);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_dp", 32'(dp), 32'h1);
    check("async_rst_frame_done", 32'(frame_done), 32'h0);
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    expf(9, D0, D0, D0, D0, 4'b0000, 4'b0000);
    expf(10, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 4'b0100, 4'b0000);
    nrst = 1'b1;
    sync(9, 3);
    do_load(16'h4321, 4'b0100);
    sync(11, 0);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
